// File: rtl/cfg_writer_pkg.sv
// Shared definitions for the configuration frame writer: sync byte, FSM state
// encoding and register map sizing.
package cfg_writer_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         REG_COUNT_DEF = 38;
  localparam int         WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_WRITE
  } state_t;

  // 9-bit compare so start+count cannot alias past the register map
  function automatic logic range_bad(input logic [7:0] start, input logic [7:0] n,
                                     input int reg_count);
    return (n == 8'd0) || ((9'(start) + 9'(n)) > 9'(reg_count));
  endfunction

endpackage

// File: rtl/imodbus.sv
// Register write bus between the frame writer and the configuration register file.
interface IModBus #(
  parameter int ADRR_SIZE = 6,
  parameter int DATA_SIZE = 32
);
  logic                 awvalid;
  logic                 dwvalid;
  logic                 wready;
  logic [ADRR_SIZE-1:0] waddr;
  logic [DATA_SIZE-1:0] wdata;

  modport master (output awvalid, output dwvalid, output waddr, output wdata, input wready);
  modport slave  (input awvalid, input dwvalid, input waddr, input wdata, output wready);
endinterface

// File: rtl/cfg_word_packer.sv
// Assembles four little-endian bytes into one data word; the first byte ends up
// in the least significant position.
module cfg_word_packer #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 clr,
  input  logic                 shift,
  input  logic [7:0]           din,
  output logic [DATA_SIZE-1:0] word_next,
  output logic                 last
);

  logic [1:0]           idx;
  logic [DATA_SIZE-1:0] shreg;

  assign word_next = {din, shreg[DATA_SIZE-1:8]};
  assign last      = shift && (idx == 2'd3);

  always_ff @(posedge aclk) begin
    if (areset || clr) begin
      idx   <= 2'd0;
      shreg <= '0;
    end else if (shift) begin
      shreg <= word_next;
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/cfg_writer.sv
// Byte-stream command decoder: parses A5/ADDR/COUNT/data frames and issues
// register writes on the IModBus master port.
//
// state    | meaning
// IDLE     | hunting for sync byte, discarding everything else
// ADDR     | waiting for start address byte
// COUNT    | waiting for word count byte
// DATA     | collecting 4 bytes of the current word
// WRITE    | holding awvalid/dwvalid until wready
module cfg_writer
  import cfg_writer_pkg::*;
#(
  parameter int ADRR_SIZE = 6,
  parameter int DATA_SIZE = 32,
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int TIMEOUT   = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  IModBus.master      mConfig,
  input  logic        err_clr,
  output logic        busy,
  output logic        err_sticky,
  output logic [15:0] frames_ok
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [ADRR_SIZE-1:0] addr_q;
  logic [7:0]           remain_q;
  logic [TW-1:0]        idle_cnt;

  logic                 accept;
  logic                 active;
  logic                 timeout;
  logic                 addr_bad;
  logic                 cnt_bad;
  logic                 err_evt;
  logic [DATA_SIZE-1:0] pk_word;
  logic                 pk_last;

  assign accept   = s_tvalid && s_tready;
  assign active   = (state == ST_ADDR) || (state == ST_COUNT) || (state == ST_DATA);
  assign timeout  = active && !accept && (idle_cnt == '0);
  assign addr_bad = 9'(s_tdata) >= 9'(REG_COUNT);
  assign cnt_bad  = range_bad(8'(addr_q), s_tdata, REG_COUNT);
  assign err_evt  = timeout ||
                    (accept && (((state == ST_ADDR) && addr_bad) ||
                                ((state == ST_COUNT) && cnt_bad)));
  assign busy     = (state != ST_IDLE);

  cfg_word_packer #(.DATA_SIZE(DATA_SIZE)) u_packer (
    .aclk      (aclk),
    .areset    (areset),
    .clr       (state != ST_DATA),
    .shift     (accept && (state == ST_DATA)),
    .din       (s_tdata),
    .word_next (pk_word),
    .last      (pk_last)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= ST_IDLE;
      s_tready        <= 1'b0;
      mConfig.awvalid <= 1'b0;
      mConfig.dwvalid <= 1'b0;
      mConfig.waddr   <= '0;
      mConfig.wdata   <= '0;
      addr_q          <= '0;
      remain_q        <= '0;
      idle_cnt        <= '0;
      err_sticky      <= 1'b0;
      frames_ok       <= '0;
    end else begin
      // a new error wins over a simultaneous clear
      err_sticky <= err_evt || (err_sticky && !err_clr);

      if (accept)
        idle_cnt <= TW'(TIMEOUT - 1);
      else if (active && idle_cnt != '0)
        idle_cnt <= idle_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          s_tready <= 1'b1;
          if (accept && s_tdata == SYNC_BYTE)
            state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (timeout)
            state <= ST_IDLE;
          else if (accept) begin
            if (addr_bad)
              state <= ST_IDLE;
            else begin
              addr_q <= s_tdata[ADRR_SIZE-1:0];
              state  <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (timeout)
            state <= ST_IDLE;
          else if (accept) begin
            if (cnt_bad)
              state <= ST_IDLE;
            else begin
              remain_q <= s_tdata;
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (timeout)
            state <= ST_IDLE;
          else if (pk_last) begin
            state           <= ST_WRITE;
            s_tready        <= 1'b0;
            mConfig.awvalid <= 1'b1;
            mConfig.dwvalid <= 1'b1;
            mConfig.waddr   <= addr_q;
            mConfig.wdata   <= pk_word;
          end
        end
        ST_WRITE: begin
          if (mConfig.wready) begin
            mConfig.awvalid <= 1'b0;
            mConfig.dwvalid <= 1'b0;
            s_tready        <= 1'b1;
            addr_q          <= addr_q + 1'b1;
            remain_q        <= remain_q - 8'd1;
            if (remain_q == 8'd1) begin
              frames_ok <= frames_ok + 16'd1;
              state     <= ST_IDLE;
            end else
              state <= ST_DATA;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_writer.sv
// Directed bench for cfg_writer: frame parsing, wready stalls, range errors,
// inter-byte timeout and reset in the middle of a write.
module tb_cfg_writer;

  localparam int TIMEOUT = 1024;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        err_sticky;
  logic [15:0] frames_ok;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aw_seen = 0;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  IModBus #(.ADRR_SIZE(6), .DATA_SIZE(32)) bus ();

  cfg_writer #(.ADRR_SIZE(6), .DATA_SIZE(32), .REG_COUNT(38), .TIMEOUT(TIMEOUT)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .mConfig    (bus),
    .err_clr    (err_clr),
    .busy       (busy),
    .err_sticky (err_sticky),
    .frames_ok  (frames_ok)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // write completions happen on the next rising edge; record them mid-cycle
  always @(negedge aclk) begin
    if (!areset && bus.awvalid) aw_seen++;
    if (!areset && bus.awvalid && bus.wready) begin
      wa_q.push_back(bus.waddr);
      wd_q.push_back(bus.wdata);
      wc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && n < 50) begin tick(1); n++; end
    if (n >= 50) chk("send_byte_ready_wait", 1, 0);
    tick(1);
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i]);
    s_tvalid = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    aw_seen = 0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
  endtask

  initial begin
    int bad;
    bus.wready = 1'b1;

    // reset state
    tick(3);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_awvalid", {bus.awvalid, bus.dwvalid}, 0);
    chk("rst_waddr_wdata", {bus.waddr, bus.wdata}, 0);
    chk("rst_busy_err", {busy, err_sticky}, 0);
    chk("rst_frames_ok", frames_ok, 0);
    areset = 1'b0;
    tick(1);
    chk("idle_s_tready", s_tready, 1);

    // two-word frame with wready tied high
    clear_log();
    send_bytes('{8'hA5, 8'h04, 8'h02, 8'h11, 8'h22, 8'h33});
    send_byte(8'h44);
    chk("w1_latency_awvalid", {bus.awvalid, bus.dwvalid, s_tready}, 3'b110);
    chk("w1_addr_data", {bus.waddr, bus.wdata}, {6'd4, 32'h44332211});
    send_bytes('{8'h55, 8'h66, 8'h77, 8'h88});
    tick(4);
    chk("f1_nwrites", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("f1_w0", {wa_q[0], wd_q[0]}, {6'd4, 32'h44332211});
      chk("f1_w1", {wa_q[1], wd_q[1]}, {6'd5, 32'h88776655});
      chk("f1_b2b_cycles", wc_q[1] - wc_q[0], 5);
    end
    chk("f1_frames_ok", frames_ok, 1);
    chk("f1_err_busy", {err_sticky, busy}, 0);

    // same frame, wready stalled beyond TIMEOUT on the first word
    clear_log();
    bus.wready = 1'b0;
    send_bytes('{8'hA5, 8'h04, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44});
    bad = 0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      if (!(bus.awvalid && bus.dwvalid && !s_tready && busy && !err_sticky &&
            bus.waddr == 6'd4 && bus.wdata == 32'h44332211)) bad++;
      tick(1);
    end
    chk("stall_hold_stable", bad, 0);
    chk("stall_no_write", wa_q.size(), 0);
    bus.wready = 1'b1;
    send_bytes('{8'h55, 8'h66, 8'h77, 8'h88});
    tick(4);
    chk("f2_nwrites", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("f2_w0", {wa_q[0], wd_q[0]}, {6'd4, 32'h44332211});
      chk("f2_w1", {wa_q[1], wd_q[1]}, {6'd5, 32'h88776655});
    end
    chk("f2_frames_ok", frames_ok, 2);
    chk("f2_err", err_sticky, 0);

    // start address out of range; trailing bytes are discarded in IDLE
    clear_log();
    send_bytes('{8'hA5, 8'h26});
    chk("addr38_err_busy", {err_sticky, busy}, 2'b10);
    send_bytes('{8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
    tick(3);
    chk("addr38_no_aw", aw_seen, 0);
    pulse_err_clr();
    chk("err_clr", err_sticky, 0);

    // 36 + 3 > 38
    send_bytes('{8'hA5, 8'h24, 8'h03});
    chk("cnt_over_err", {err_sticky, busy}, 2'b10);
    send_bytes('{8'h01, 8'h00, 8'h00, 8'h00});
    tick(3);
    chk("cnt_over_no_aw", aw_seen, 0);
    pulse_err_clr();

    // 36 + 2 == 38 is the last legal span
    send_bytes('{8'hA5, 8'h24, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
    tick(4);
    chk("edge_nwrites", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("edge_w0", {wa_q[0], wd_q[0]}, {6'd36, 32'h00000001});
      chk("edge_w1", {wa_q[1], wd_q[1]}, {6'd37, 32'h00000002});
    end
    chk("edge_frames_ok_err", {frames_ok, err_sticky}, {16'd3, 1'b0});

    // zero count with err_clr on the same edge: error wins
    clear_log();
    send_bytes('{8'hA5, 8'h00});
    s_tdata = 8'h00; s_tvalid = 1'b1; err_clr = 1'b1;
    tick(1);
    s_tvalid = 1'b0; err_clr = 1'b0;
    chk("n0_set_wins", {err_sticky, busy}, 2'b10);
    pulse_err_clr();
    chk("n0_cleared", err_sticky, 0);

    // inter-byte timeout mid-word
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22});
    tick(TIMEOUT - 1);
    chk("to_not_yet", {err_sticky, busy}, 2'b01);
    tick(1);
    chk("to_fired", {err_sticky, busy}, 2'b10);
    pulse_err_clr();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    tick(4);
    chk("to_recover_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1)
      chk("to_recover_w0", {wa_q[0], wd_q[0]}, {6'd0, 32'hEFBEADDE});
    chk("to_recover_frames_err", {frames_ok, err_sticky}, {16'd4, 1'b0});

    // reset while holding a write
    clear_log();
    bus.wready = 1'b0;
    send_bytes('{8'hA5, 8'h10, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04});
    tick(2);
    chk("mid_write_aw", bus.awvalid, 1);
    areset = 1'b1;
    tick(1);
    chk("rst_mid_aw_busy", {bus.awvalid, bus.dwvalid, busy, s_tready}, 0);
    chk("rst_mid_frames_bus", {frames_ok, bus.waddr, bus.wdata}, 0);
    areset = 1'b0;
    bus.wready = 1'b1;
    tick(4);
    chk("rst_mid_dropped", wa_q.size(), 0);
    send_bytes('{8'h11, 8'h22, 8'h04, 8'hA5, 8'h05, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04});
    tick(4);
    chk("post_rst_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1)
      chk("post_rst_w0", {wa_q[0], wd_q[0]}, {6'd5, 32'h04030201});
    chk("post_rst_frames_err", {frames_ok, err_sticky}, {16'd1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
